// File: rtl/contador_modn_cascada.sv
// rtl/contador_modn_cascada.sv - multi-digit modulo-N up/down counter with cascade pulses (option: MOD_CNT_SAT_EN)
module contador_modn_cascada #(
    parameter int DIGITS = 2,
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                incremento,
    input  logic                decremento,
    input  logic                carga,
    input  logic [DIGITS*W-1:0] dato_carga,
    output logic [DIGITS*W-1:0] cuenta,
    output logic                acarreo,
    output logic                prestamo
);
    // MODULO may equal 2^W, so the load range check needs one extra bit
    localparam logic [W:0]   MOD_EXT = (W+1)'(MODULO);
    localparam logic [W-1:0] MAX_D   = W'(MODULO - 1);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [DIGITS*W-1:0] cuenta_q, cuenta_d;
    logic                acarreo_q, acarreo_d;
    logic                prestamo_q, prestamo_d;
    logic                all_max, all_zero, ripple;
    logic [W-1:0]        dig;

    // Next count and pulses: load beats a single-direction step, everything else holds
    always_comb begin
        cuenta_d   = cuenta_q;
        acarreo_d  = 1'b0;
        prestamo_d = 1'b0;
        all_max    = 1'b1;
        all_zero   = 1'b1;
        ripple     = 1'b1;
        dig        = '0;

        for (int i = 0; i < DIGITS; i++) begin
            if (cuenta_q[i*W +: W] != MAX_D) all_max  = 1'b0;
            if (cuenta_q[i*W +: W] != '0)    all_zero = 1'b0;
        end

        if (carga) begin
            // Out-of-range digits are forced to 0 so no digit ever exceeds MODULO-1
            for (int i = 0; i < DIGITS; i++) begin
                dig = dato_carga[i*W +: W];
                cuenta_d[i*W +: W] = ({1'b0, dig} >= MOD_EXT) ? '0 : dig;
            end
        end else if (incremento && !decremento) begin
            // Ripple upward while the digits below are all at MODULO-1
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    dig = cuenta_q[i*W +: W];
                    if (dig == MAX_D) begin
                        cuenta_d[i*W +: W] = '0;
                    end else begin
                        cuenta_d[i*W +: W] = dig + ONE;
                        ripple = 1'b0;
                    end
                end
            end
            acarreo_d = all_max;
`ifdef MOD_CNT_SAT_EN
            if (all_max) cuenta_d = cuenta_q;
`endif
        end else if (decremento && !incremento) begin
            // Ripple downward while the digits below are all at 0
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    dig = cuenta_q[i*W +: W];
                    if (dig == '0) begin
                        cuenta_d[i*W +: W] = MAX_D;
                    end else begin
                        cuenta_d[i*W +: W] = dig - ONE;
                        ripple = 1'b0;
                    end
                end
            end
            prestamo_d = all_zero;
`ifdef MOD_CNT_SAT_EN
            if (all_zero) cuenta_d = cuenta_q;
`endif
        end
    end

    // State and pulse registers; reset clears the count and kills any pulse at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_q   <= '0;
            acarreo_q  <= 1'b0;
            prestamo_q <= 1'b0;
        end else begin
            cuenta_q   <= cuenta_d;
            acarreo_q  <= acarreo_d;
            prestamo_q <= prestamo_d;
        end
    end

    assign cuenta   = cuenta_q;
    assign acarreo  = acarreo_q;
    assign prestamo = prestamo_q;

endmodule
